// File: rtl/ps2_keycode_rx.sv
// rtl/ps2_keycode_rx.sv - PS/2 set-2 receiver with E0/F0 prefix tracking and HID keycode output
//
// Ports:
//   Clk        - system clock
//   Reset_n    - asynchronous active-low reset
//   PS2_CLK    - raw PS/2 clock pin (asynchronous, idle high)
//   PS2_DAT    - raw PS/2 data pin (asynchronous)
//   keycode    - HID code of the currently held mapped key, 0x00 when none
//   scan_valid - one-cycle pulse, a frame passed start/parity/stop checks
//   scan_code  - data byte of the last good frame
//   parity_err - one-cycle pulse, parity check failed
//   frame_err  - one-cycle pulse, bad start bit, bad stop bit or inter-edge timeout

module ps2_keycode_rx #(
    parameter int CLK_HZ     = 50000000,
    parameter int TIMEOUT_US = 200
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] keycode,
    output logic       scan_valid,
    output logic [7:0] scan_code,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int TIMEOUT_CYC = (CLK_HZ / 1000000) * TIMEOUT_US;
    localparam int TMO_W       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // Input conditioning: two-flop synchronizers preset to the idle level
    logic clk_s1, clk_s2, clk_prev;
    logic dat_s1, dat_s2;

    // Falling-edge strobe and the data bit captured with it, registered so
    // the frame FSM sees a clean one-cycle event.
    logic fall_q;
    logic dat_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
            fall_q   <= 1'b0;
            dat_q    <= 1'b0;
        end else begin
            clk_s1   <= PS2_CLK;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= PS2_DAT;
            dat_s2   <= dat_s1;
            fall_q   <= clk_prev & ~clk_s2;
            dat_q    <= dat_s2;
        end
    end

    // Frame FSM
    state_t           state, state_n;
    logic [2:0]       bit_cnt, bit_cnt_n;
    logic [7:0]       shift, shift_n;
    logic             par_bit, par_bit_n;
    logic [TMO_W-1:0] tmo_cnt, tmo_cnt_n;
    logic             valid_n, perr_n, ferr_n;
    logic [7:0]       code_n;
    logic             tmo_hit;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= ST_IDLE;
            bit_cnt    <= 3'd0;
            shift      <= 8'h00;
            par_bit    <= 1'b0;
            tmo_cnt    <= '0;
            scan_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            scan_code  <= 8'h00;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shift      <= shift_n;
            par_bit    <= par_bit_n;
            tmo_cnt    <= tmo_cnt_n;
            scan_valid <= valid_n;
            parity_err <= perr_n;
            frame_err  <= ferr_n;
            scan_code  <= code_n;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        par_bit_n = par_bit;
        valid_n   = 1'b0;
        perr_n    = 1'b0;
        ferr_n    = 1'b0;
        code_n    = scan_code;

        // An edge in the same cycle restarts the gap count, so it wins over timeout
        tmo_hit = (state != ST_IDLE) && !fall_q && (tmo_cnt == TMO_LAST);

        if (state == ST_IDLE || fall_q) begin
            tmo_cnt_n = '0;
        end else begin
            tmo_cnt_n = tmo_cnt + TMO_W'(1);
        end

        case (state)
            ST_IDLE: begin
                if (fall_q) begin
                    if (!dat_q) begin
                        state_n   = ST_DATA;
                        bit_cnt_n = 3'd0;
                    end else begin
                        ferr_n = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (fall_q) begin
                    shift_n = {dat_q, shift[7:1]};
                    if (bit_cnt == 3'd7) begin
                        state_n = ST_PARITY;
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (fall_q) begin
                    par_bit_n = dat_q;
                    state_n   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall_q) begin
                    state_n = ST_IDLE;
                    if (!dat_q) begin
                        ferr_n = 1'b1;
                    end else if (^{shift, par_bit} == 1'b0) begin
                        perr_n = 1'b1;
                    end else begin
                        valid_n = 1'b1;
                        code_n  = shift;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        if (tmo_hit) begin
            state_n = ST_IDLE;
            ferr_n  = 1'b1;
        end
    end

    // Scancode decoder
    logic       ext, brk;
    logic       map_hit;
    logic [7:0] map_hid;

    always_comb begin
        map_hit = 1'b1;
        map_hid = 8'h00;
        case ({ext, scan_code})
            9'h0_1C: map_hid = 8'h04;
            9'h0_23: map_hid = 8'h07;
            9'h0_1D: map_hid = 8'h1A;
            9'h0_1B: map_hid = 8'h16;
            9'h0_29: map_hid = 8'h2C;
            9'h0_5A: map_hid = 8'h28;
            9'h1_75: map_hid = 8'h52;
            9'h1_72: map_hid = 8'h51;
            9'h1_6B: map_hid = 8'h50;
            9'h1_74: map_hid = 8'h4F;
            default: map_hit = 1'b0;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ext     <= 1'b0;
            brk     <= 1'b0;
            keycode <= 8'h00;
        end else if (scan_valid) begin
            if (scan_code == 8'hE0) begin
                ext <= 1'b1;
            end else if (scan_code == 8'hF0) begin
                brk <= 1'b1;
            end else begin
                if (map_hit) begin
                    if (brk) begin
                        // Releasing an older key must not clear a newer held one
                        if (keycode == map_hid) begin
                            keycode <= 8'h00;
                        end
                    end else begin
                        keycode <= map_hid;
                    end
                end
                ext <= 1'b0;
                brk <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// tb/tb_ps2_keycode_rx.sv - randomized self-checking bench for ps2_keycode_rx

module tb_ps2_keycode_rx;

    localparam int CLK_HZ     = 50000000;
    localparam int TIMEOUT_US = 4;
    localparam int TMO_CYC    = (CLK_HZ / 1000000) * TIMEOUT_US;
    localparam int HALF       = 15;

    logic       Clk;
    logic       Reset_n;
    logic       PS2_CLK;
    logic       PS2_DAT;
    logic [7:0] keycode;
    logic       scan_valid;
    logic [7:0] scan_code;
    logic       parity_err;
    logic       frame_err;

    ps2_keycode_rx #(
        .CLK_HZ    (CLK_HZ),
        .TIMEOUT_US(TIMEOUT_US)
    ) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .PS2_CLK   (PS2_CLK),
        .PS2_DAT   (PS2_DAT),
        .keycode   (keycode),
        .scan_valid(scan_valid),
        .scan_code (scan_code),
        .parity_err(parity_err),
        .frame_err (frame_err)
    );

    initial Clk = 1'b0;
    always #10 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pulse counters sampled away from the active edge
    int n_valid = 0;
    int n_perr  = 0;
    int n_ferr  = 0;

    always @(negedge Clk) begin
        if (Reset_n) begin
            if (scan_valid) n_valid++;
            if (parity_err) n_perr++;
            if (frame_err)  n_ferr++;
            if (scan_valid || parity_err || frame_err)
                chk("pulse_excl", 32'(int'(scan_valid) + int'(parity_err) + int'(frame_err)), 32'd1);
        end
    end

    // Reference model: byte-level decoder driven from lookup tables
    logic [7:0] m_kc;
    bit         m_ext, m_brk;
    logic [7:0] m_code;

    logic [7:0] tbl_set2 [10] = '{8'h1C, 8'h23, 8'h1D, 8'h1B, 8'h29, 8'h5A, 8'h75, 8'h72, 8'h6B, 8'h74};
    logic [7:0] tbl_hid  [10] = '{8'h04, 8'h07, 8'h1A, 8'h16, 8'h2C, 8'h28, 8'h52, 8'h51, 8'h50, 8'h4F};
    bit         tbl_ext  [10] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1};

    task automatic model_reset();
        m_kc   = 8'h00;
        m_ext  = 0;
        m_brk  = 0;
        m_code = 8'h00;
    endtask

    task automatic model_byte(input logic [7:0] b);
        m_code = b;
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            for (int i = 0; i < 10; i++) begin
                if (tbl_set2[i] == b && tbl_ext[i] == m_ext) begin
                    if (!m_brk) m_kc = tbl_hid[i];
                    else if (m_kc == tbl_hid[i]) m_kc = 8'h00;
                end
            end
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic ps2_bit(input logic v);
        PS2_DAT = v;
        wait_cyc(HALF);
        PS2_CLK = 1'b0;
        wait_cyc(HALF);
        PS2_CLK = 1'b1;
    endtask

    // Drive the first nbits of a frame (11 = complete frame)
    task automatic ps2_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(bits[i]);
        PS2_DAT = 1'b1;
    endtask

    task automatic send(input string tag, input logic [7:0] b, input bit bad_par, input bit bad_stop);
        int v0, p0, f0;
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
        ps2_frame(b, bad_par, bad_stop, 11);
        wait_cyc(12);
        if (!bad_par && !bad_stop) model_byte(b);
        chk({tag, "_valid"}, 32'(n_valid - v0), (!bad_par && !bad_stop) ? 32'd1 : 32'd0);
        chk({tag, "_perr"},  32'(n_perr - p0),  (bad_par && !bad_stop) ? 32'd1 : 32'd0);
        chk({tag, "_ferr"},  32'(n_ferr - f0),  bad_stop ? 32'd1 : 32'd0);
        chk({tag, "_code"},  32'(scan_code), 32'(m_code));
        chk({tag, "_kc"},    32'(keycode),   32'(m_kc));
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        wait_cyc(3);
        model_reset();
        chk("rst_kc",    32'(keycode), 32'h0);
        chk("rst_code",  32'(scan_code), 32'h0);
        chk("rst_pulse", 32'({scan_valid, parity_err, frame_err}), 32'h0);
        Reset_n = 1'b1;
        wait_cyc(3);
    endtask

    logic [7:0] pool [16] = '{8'h1C, 8'h23, 8'h1D, 8'h1B, 8'h29, 8'h5A, 8'h75, 8'h72,
                              8'h6B, 8'h74, 8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'h15, 8'h42};

    initial begin
        int f0;
        PS2_CLK = 1'b1;
        PS2_DAT = 1'b1;
        Reset_n = 1'b0;
        model_reset();
        wait_cyc(2);
        do_reset();

        // Make / break basics
        send("a_make", 8'h1C, 0, 0);
        chk("a_hid", 32'(keycode), 32'h04);
        send("a_f0", 8'hF0, 0, 0);
        send("a_brk", 8'h1C, 0, 0);
        chk("a_rel", 32'(keycode), 32'h00);

        // Last make wins, older break ignored
        send("ad_a", 8'h1C, 0, 0);
        send("ad_d", 8'h23, 0, 0);
        send("ad_f0", 8'hF0, 0, 0);
        send("ad_ba", 8'h1C, 0, 0);
        chk("ad_hold", 32'(keycode), 32'h07);
        send("ad_f0b", 8'hF0, 0, 0);
        send("ad_bd", 8'h23, 0, 0);

        // Extended make and break, then 75 without prefix
        send("up_e0", 8'hE0, 0, 0);
        send("up_mk", 8'h75, 0, 0);
        chk("up_hid", 32'(keycode), 32'h52);
        send("up_e0b", 8'hE0, 0, 0);
        send("up_f0", 8'hF0, 0, 0);
        send("up_brk", 8'h75, 0, 0);
        send("kp8", 8'h75, 0, 0);

        // Parity error then good frame
        send("perr", 8'h1C, 1, 0);
        send("space", 8'h29, 0, 0);
        chk("space_hid", 32'(keycode), 32'h2C);

        // Timeout after 4 data bits (start + 4)
        f0 = n_ferr;
        ps2_frame(8'h1C, 0, 0, 5);
        wait_cyc(TMO_CYC + 40);
        chk("tmo_ferr", 32'(n_ferr - f0), 32'd1);
        send("w_after", 8'h1D, 0, 0);
        chk("w_hid", 32'(keycode), 32'h1A);

        // Bad stop bit
        send("stop0", 8'h23, 0, 1);

        // Stray falling edge with data high while idle
        f0 = n_ferr;
        ps2_bit(1'b1);
        wait_cyc(12);
        chk("idle_ferr", 32'(n_ferr - f0), 32'd1);

        // Reset mid-frame
        ps2_frame(8'h5A, 0, 0, 6);
        do_reset();
        send("ent", 8'h5A, 0, 0);
        chk("ent_hid", 32'(keycode), 32'h28);

        // Reset mid-prefix clears ext
        send("pre_e0", 8'hE0, 0, 0);
        do_reset();
        send("pre_75", 8'h75, 0, 0);

        // Randomized byte stream with occasional parity errors
        for (int i = 0; i < 50; i++) begin
            logic [7:0] b;
            bit bp;
            b  = pool[$urandom_range(15, 0)];
            bp = ($urandom_range(9, 0) == 0);
            send("rnd", b, bp, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #50ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
